// File: rtl/fir2d_pkg.sv
// Shared 2D FIR definitions: coefficient Q-format, accumulator widths and the
// round/clip used by both the vertical and horizontal stages.
package fir2d_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned COEFF_W    = 14;
    localparam int unsigned COEFF_FRAC = COEFF_W - 2;
    localparam int unsigned PROD_W     = COEFF_W + DATA_W;
    localparam int unsigned SUM_W      = PROD_W + 2;

    typedef logic [DATA_W-1:0]       pixel_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    // Negative -> 0, overflow -> all ones, otherwise round half up without wrapping.
    function automatic pixel_t round_clip(input sum_t s);
        pixel_t q;
        logic   rnd;
        q   = s[PROD_W-3:COEFF_FRAC];
        rnd = s[COEFF_FRAC-1];
        if (s[SUM_W-1]) begin
            round_clip = '0;
        end else if (|s[SUM_W-2:PROD_W-2]) begin
            round_clip = '1;
        end else if ((&q) && rnd) begin
            round_clip = '1;
        end else begin
            round_clip = q + pixel_t'(rnd);
        end
    endfunction

endpackage

// File: rtl/vfilter_linebuf_if.sv
// Pixel stream into the vertical filter and its filtered/centre-tap output stream.
interface vfilter_linebuf_if #(
    parameter int unsigned DATA_WIDTH = fir2d_pkg::DATA_W
) ();
    logic                  valid_i;
    logic                  sof_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [DATA_WIDTH-1:0] center_o;
    logic                  valid_o;

    modport master (
        output valid_i, sof_i, data_i,
        input  ready_o, data_o, center_o, valid_o
    );

    modport slave (
        input  valid_i, sof_i, data_i,
        output ready_o, data_o, center_o, valid_o
    );
endinterface

// File: rtl/fir_line_ram.sv
// Single-port line buffer: read-before-write at one address, registered read.
module fir_line_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 640,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/vfilter_linebuf.sv
// Vertical 3-tap FIR over two buffered lines with edge replication on the first two rows.
// Pipeline: RAM read -> S0 taps -> S1 products -> S2 sum; data_o is round/clip of S2.
module vfilter_linebuf
    import fir2d_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned COEFF_WIDTH = COEFF_W,
    parameter int unsigned LINE_WIDTH  = 640,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [COEFF_WIDTH-1:0] coeff00_v_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff01_v_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff02_v_i,
    vfilter_linebuf_if.slave              bus
);
    localparam int unsigned PW = COEFF_WIDTH + DATA_WIDTH;
    localparam int unsigned SW = PW + 2;

    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_col, w_col_cur, w_col_nxt;
    logic [1:0]            r_row, w_row_cur, w_row_nxt;

    always_comb begin
        w_col_cur = bus.sof_i ? '0 : r_col;
        w_row_cur = bus.sof_i ? 2'd0 : r_row;
        w_row_nxt = w_row_cur;
        if (w_col_cur == ADDR_WIDTH'(LINE_WIDTH - 1)) begin
            w_col_nxt = '0;
            if (w_row_cur != 2'd2) w_row_nxt = w_row_cur + 2'd1;
        end else begin
            w_col_nxt = w_col_cur + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_col   <= '0;
            r_row   <= 2'd0;
        end else begin
            r_ready <= 1'b1;
            if (bus.valid_i) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
            end
        end
    end

    // lb1 is updated one cycle late, once the old lb0 word has come out of its read register.
    logic                  r_va;
    logic [DATA_WIDTH-1:0] r_data_a;
    logic [1:0]            r_row_a;
    logic [ADDR_WIDTH-1:0] r_col_a;
    logic [DATA_WIDTH-1:0] w_lb0_rd, w_lb1_rd;

    fir_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LINE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lb0 (
        .clk     (clk),
        .i_en    (bus.valid_i),
        .i_addr  (w_col_cur),
        .i_wdata (bus.data_i),
        .o_rdata (w_lb0_rd)
    );

    fir_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LINE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lb1 (
        .clk     (clk),
        .i_en    (r_va),
        .i_addr  (r_col_a),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    logic                          r_v0, r_v1, r_v2, r_full0;
    logic [DATA_WIDTH-1:0]         r_mid0, r_bot0, r_mid1, r_mid2;
    logic signed [PW-1:0]          r_prod0, r_prod1, r_prod2;
    logic signed [SW-1:0]          r_sum;
    logic [DATA_WIDTH-1:0]         w_top;
    logic signed [DATA_WIDTH:0]    w_top_s, w_mid_s, w_bot_s;

    // Rows 0 and 1 replicate the mid tap upward; only row >= 2 has a real r-2 line.
    always_comb begin
        w_top   = r_full0 ? w_lb1_rd : r_mid0;
        w_top_s = $signed({1'b0, w_top});
        w_mid_s = $signed({1'b0, r_mid0});
        w_bot_s = $signed({1'b0, r_bot0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_va     <= 1'b0;
            r_data_a <= '0;
            r_row_a  <= 2'd0;
            r_col_a  <= '0;
            r_v0     <= 1'b0;
            r_full0  <= 1'b0;
            r_mid0   <= '0;
            r_bot0   <= '0;
            r_v1     <= 1'b0;
            r_mid1   <= '0;
            r_prod0  <= '0;
            r_prod1  <= '0;
            r_prod2  <= '0;
            r_v2     <= 1'b0;
            r_mid2   <= '0;
            r_sum    <= '0;
        end else begin
            r_va <= bus.valid_i;
            r_v0 <= r_va;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
            if (bus.valid_i) begin
                r_data_a <= bus.data_i;
                r_row_a  <= w_row_cur;
                r_col_a  <= w_col_cur;
            end
            if (r_va) begin
                r_mid0  <= (r_row_a == 2'd0) ? r_data_a : w_lb0_rd;
                r_bot0  <= r_data_a;
                r_full0 <= (r_row_a == 2'd2);
            end
            if (r_v0) begin
                r_prod0 <= PW'(w_top_s) * PW'(coeff00_v_i);
                r_prod1 <= PW'(w_mid_s) * PW'(coeff01_v_i);
                r_prod2 <= PW'(w_bot_s) * PW'(coeff02_v_i);
                r_mid1  <= r_mid0;
            end
            if (r_v1) begin
                r_sum  <= SW'(r_prod0) + SW'(r_prod1) + SW'(r_prod2);
                r_mid2 <= r_mid1;
            end
        end
    end

    assign bus.ready_o  = r_ready;
    assign bus.valid_o  = r_v2;
    assign bus.center_o = r_mid2;
    assign bus.data_o   = round_clip(r_sum);
endmodule
